// File: rtl/mem_responder.sv
// Word-addressed synchronous RAM responder for the datapath memory bus.
// Captures a Read/Write request, inserts WAIT_CYC wait states, then answers with a one-cycle Done.
module mem_responder #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 512,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYC);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_op_wr;
  logic [DATA_W-1:0] r_mdat;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_mem_we;

  assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx      = r_addr[IDX_W-1:0];
  // Writes commit only on the edge leaving RESP, so a reset before then drops them.
  assign w_mem_we   = (r_state == S_RESP) && r_op_wr && w_in_range;

  // NOTE: the RAM array has no reset on purpose; contents survive Clear and
  // keeping it out of the reset domain lets it map onto a real memory macro.
  always_ff @(posedge Clock) begin
    if (w_mem_we) r_mem[w_idx] <= r_data;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware regardless of statement order.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_op_wr <= 1'b0;
      r_mdat  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Read && Write) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_HOLD;
          end else if (Read || Write) begin
            r_addr  <= Address;
            r_data  <= DataIn;
            r_op_wr <= Write;
            if (WAIT_CYC == 0) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= WAIT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= S_RESP;
        end
        S_RESP: begin
          r_done <= 1'b1;
          r_err  <= !w_in_range;
          if (!r_op_wr) r_mdat <= w_in_range ? r_mem[w_idx] : '0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          // A held request level must not retrigger; wait for both to drop.
          if (!Read && !Write) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Mdatain = r_mdat;
  assign Done    = r_done;
  assign Err     = r_err;
  assign Busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Table-driven bench for mem_responder: one cycle per vector, outputs compared on the falling edge.
// Instance m uses defaults (WAIT_CYC=2, DEPTH=512); instance s uses WAIT_CYC=0, DEPTH=256.
module tb_mem_responder;

  logic        Clock;
  logic        Clear;
  logic        m_rd, m_wr, s_rd, s_wr;
  logic [8:0]  m_addr, s_addr;
  logic [31:0] m_din, s_din;
  logic [31:0] m_mdat, s_mdat;
  logic        m_done, m_busy, m_err, s_done, s_busy, s_err;

  int n_vec = 0;
  int n_mis = 0;

  mem_responder dut_m (
    .Clock(Clock), .Clear(Clear), .Read(m_rd), .Write(m_wr),
    .Address(m_addr), .DataIn(m_din), .Mdatain(m_mdat),
    .Done(m_done), .Busy(m_busy), .Err(m_err)
  );

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYC(0)) dut_s (
    .Clock(Clock), .Clear(Clear), .Read(s_rd), .Write(s_wr),
    .Address(s_addr), .DataIn(s_din), .Mdatain(s_mdat),
    .Done(s_done), .Busy(s_busy), .Err(s_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit          sel;
    logic        clr, rd, wr;
    logic [8:0]  addr;
    logic [31:0] din;
    logic        busy, done, err;
    bit          chk_m;
    logic [31:0] mdat;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit sel, input logic clr, rd, wr, input logic [8:0] addr,
                     input logic [31:0] din, input logic busy, done, err,
                     input bit chk_m, input logic [31:0] mdat);
    vec_t v;
    v.sel = sel; v.clr = clr; v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
    v.busy = busy; v.done = done; v.err = err; v.chk_m = chk_m; v.mdat = mdat;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, exp);
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  localparam bit M = 1'b0;
  localparam bit S = 1'b1;

  initial begin
    int cyc;
    Clear = 1'b0;
    m_rd = 0; m_wr = 0; m_addr = '0; m_din = '0;
    s_rd = 0; s_wr = 0; s_addr = '0; s_din = '0;

    //   sel clr rd wr addr     din           busy done err chk mdat
    // Reset with Read held, then the access starts at the first edge after release
    add(M, 0, 1, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h0);
    add(M, 0, 1, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h0);
    add(M, 1, 1, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h0);
    add(M, 1, 1, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h0);
    add(M, 1, 1, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h0);
    add(M, 1, 1, 0, 9'h000, 32'h0,        1, 1, 0, 0, 32'h0);
    add(M, 1, 1, 0, 9'h000, 32'h0,        1, 0, 0, 0, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 32'h0);
    // Preload 0x055; inputs change during WAIT and must be ignored
    add(M, 1, 0, 1, 9'h055, 32'h08800055, 1, 0, 0, 0, 32'h0);
    add(M, 1, 0, 0, 9'h0AA, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0);
    add(M, 1, 0, 0, 9'h0AA, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 0, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 0, 32'h0);
    // Pulsed read of 0x055
    add(M, 1, 1, 0, 9'h055, 32'h0,        1, 0, 0, 0, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 0, 0, 0, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 0, 0, 0, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h08800055);
    // Write 0x1F0 (Mdatain must not move), then read it back
    add(M, 1, 0, 1, 9'h1F0, 32'hDEADBEEF, 1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 1, 9'h1F0, 32'hDEADBEEF, 1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 1, 9'h1F0, 32'hDEADBEEF, 1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 1, 9'h1F0, 32'hDEADBEEF, 1, 1, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h08800055);
    add(M, 1, 1, 0, 9'h1F0, 32'h0,        1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 1, 32'hDEADBEEF);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'hDEADBEEF);
    // Read of 0x055 held for 8 cycles: one Done, no retrigger
    add(M, 1, 1, 0, 9'h055, 32'h0,        1, 0, 0, 1, 32'hDEADBEEF);
    add(M, 1, 1, 0, 9'h055, 32'h0,        1, 0, 0, 1, 32'hDEADBEEF);
    add(M, 1, 1, 0, 9'h055, 32'h0,        1, 0, 0, 1, 32'hDEADBEEF);
    add(M, 1, 1, 0, 9'h055, 32'h0,        1, 1, 0, 1, 32'h08800055);
    for (int i = 0; i < 4; i++)
      add(M, 1, 1, 0, 9'h055, 32'h0,      1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h08800055);
    // Read and Write together: immediate Done+Err, no access
    add(M, 1, 1, 1, 9'h1F0, 32'h0,        1, 1, 1, 1, 32'h08800055);
    add(M, 1, 1, 1, 9'h1F0, 32'h0,        1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h08800055);
    // Old value at 0x010, then a write aborted by reset during WAIT
    add(M, 1, 0, 1, 9'h010, 32'hCAFEF00D, 1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 1, 32'h08800055);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h08800055);
    add(M, 1, 0, 1, 9'h010, 32'h12345678, 1, 0, 0, 1, 32'h08800055);
    add(M, 0, 0, 1, 9'h010, 32'h12345678, 0, 0, 0, 1, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h0);
    add(M, 1, 1, 0, 9'h010, 32'h0,        1, 0, 0, 1, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h0);
    add(M, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 1, 32'hCAFEF00D);
    add(M, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'hCAFEF00D);
    // Zero-wait instance: last in-range word, out-of-range read and dropped write
    add(S, 1, 0, 1, 9'h0FF, 32'hA5A5A5A5, 1, 0, 0, 1, 32'h0);
    add(S, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 1, 32'h0);
    add(S, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h0);
    add(S, 1, 1, 0, 9'h0FF, 32'h0,        1, 0, 0, 1, 32'h0);
    add(S, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 1, 32'hA5A5A5A5);
    add(S, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'hA5A5A5A5);
    add(S, 1, 0, 1, 9'h000, 32'h22222222, 1, 0, 0, 1, 32'hA5A5A5A5);
    add(S, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 1, 32'hA5A5A5A5);
    add(S, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'hA5A5A5A5);
    add(S, 1, 1, 0, 9'h1FF, 32'h0,        1, 0, 0, 1, 32'hA5A5A5A5);
    add(S, 1, 0, 0, 9'h000, 32'h0,        1, 1, 1, 1, 32'h0);
    add(S, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h0);
    add(S, 1, 0, 1, 9'h100, 32'h11111111, 1, 0, 0, 1, 32'h0);
    add(S, 1, 0, 0, 9'h000, 32'h0,        1, 1, 1, 1, 32'h0);
    add(S, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h0);
    add(S, 1, 1, 0, 9'h000, 32'h0,        1, 0, 0, 1, 32'h0);
    add(S, 1, 0, 0, 9'h000, 32'h0,        1, 1, 0, 1, 32'h22222222);
    add(S, 1, 0, 0, 9'h000, 32'h0,        0, 0, 0, 1, 32'h22222222);

    @(negedge Clock);
    foreach (vq[i]) begin
      Clear = vq[i].clr;
      m_rd = (vq[i].sel == M) ? vq[i].rd : 1'b0;
      m_wr = (vq[i].sel == M) ? vq[i].wr : 1'b0;
      m_addr = vq[i].addr; m_din = vq[i].din;
      s_rd = (vq[i].sel == S) ? vq[i].rd : 1'b0;
      s_wr = (vq[i].sel == S) ? vq[i].wr : 1'b0;
      s_addr = vq[i].addr; s_din = vq[i].din;
      @(negedge Clock);
      n_vec++;
      if (vq[i].sel == M) begin
        check("m_busy", i, 32'(m_busy), 32'(vq[i].busy));
        check("m_done", i, 32'(m_done), 32'(vq[i].done));
        check("m_err",  i, 32'(m_err),  32'(vq[i].err));
        if (vq[i].chk_m) check("m_mdat", i, m_mdat, vq[i].mdat);
      end else begin
        check("s_busy", i, 32'(s_busy), 32'(vq[i].busy));
        check("s_done", i, 32'(s_done), 32'(vq[i].done));
        check("s_err",  i, 32'(s_err),  32'(vq[i].err));
        if (vq[i].chk_m) check("s_mdat", i, s_mdat, vq[i].mdat);
      end
    end

    // Latency measured with a bounded wait: Done expected on the 4th falling edge
    s_rd = 0; s_wr = 0;
    m_rd = 1; m_wr = 0; m_addr = 9'h1F0;
    cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
    end while (!m_done && cyc < 20);
    n_vec++;
    check("latency_cycles", -1, 32'(cyc), 32'd4);
    check("latency_mdat", -1, m_mdat, 32'hDEADBEEF);
    @(negedge Clock);
    n_vec++;
    check("done_single_cycle", -1, 32'(m_done), 32'd0);
    check("busy_in_hold", -1, 32'(m_busy), 32'd1);
    m_rd = 0;
    @(negedge Clock);
    n_vec++;
    check("busy_release", -1, 32'(m_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
